// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host transmit path: transmitter state
//   encoding, common keyboard command/response bytes, default timing
//   parameters and the frame builder used when a command is accepted.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } tx_state_t;

  // Keyboard command / response bytes
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Default timing at a 50 MHz system clock
  localparam int DEF_INHIBIT_CYCLES = 6000;     // 120 us clock inhibit
  localparam int DEF_TIMEOUT_CYCLES = 1000000;  // 20 ms watchdog
  localparam int DEF_FILTER_LEN     = 8;

  localparam int BIT_CNT_W = 4;

  // Transmitted payload, LSB first: eight data bits then odd parity.
  function automatic logic [8:0] build_frame(input logic [7:0] data);
    return {~^data, data};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter
//   Conditions the raw PS/2 lines: both pass through a two-flop
//   synchronizer, the clock additionally through a glitch filter that only
//   changes level after FILTER_LEN consecutive identical samples. A
//   one-cycle pulse marks each filtered 1->0 clock transition. Shared with
//   the receive path.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   ps2c_in     raw PS/2 clock line
//   ps2d_in     raw PS/2 data line
//   ps2c_filt   synchronized + filtered clock level
//   ps2d_sync   synchronized data level
//   fall        one-cycle pulse on a filtered falling clock edge
module ps2_clk_filter
  import ps2_host_tx_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic ps2c_filt,
  output logic ps2d_sync,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       c_sync_reg;
  logic [1:0]       d_sync_reg;
  logic             filt_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fall_reg;

  // Synchronizers and filter come out of reset at the idle bus level (high)
  // so releasing reset can never produce a spurious falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync_reg <= 2'b11;
      d_sync_reg <= 2'b11;
      filt_reg   <= 1'b1;
      cnt_reg    <= '0;
      fall_reg   <= 1'b0;
    end else begin
      c_sync_reg <= {c_sync_reg[0], ps2c_in};
      d_sync_reg <= {d_sync_reg[0], ps2d_in};
      fall_reg   <= 1'b0;
      if (c_sync_reg[1] == filt_reg) begin
        // Any sample agreeing with the current level restarts the run.
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
        filt_reg <= c_sync_reg[1];
        cnt_reg  <= '0;
        fall_reg <= filt_reg;  // was high, now going low
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign ps2c_filt = filt_reg;
  assign ps2d_sync = d_sync_reg[1];
  assign fall      = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. Inhibits the bus, issues the start
//   bit, presents eight data bits plus odd parity on device clock falls,
//   releases data for the stop bit and checks the device ACK. A watchdog
//   aborts a stalled transfer.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   wr_ps2, din     one-cycle send request and command byte (IDLE only)
//   ps2c_in/ps2d_in raw PS/2 clock / data lines
//   ps2c_drive_low  1 = pull PS/2 clock low (open collector)
//   ps2d_drive_low  1 = pull PS/2 data low (open collector)
//   tx_busy         high whenever a transfer is in progress
//   tx_done         one-cycle pulse: frame acknowledged and bus idle
//   tx_err          one-cycle pulse: missing ACK or watchdog expiry
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  // Data is pulled low for the final eighth of the inhibit window.
  localparam int DATA_LOW_FROM = INHIBIT_CYCLES - INHIBIT_CYCLES / 8;

  logic ps2c_filt;
  logic ps2d_sync;
  logic fall;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_filt(ps2c_filt),
    .ps2d_sync(ps2d_sync),
    .fall     (fall)
  );

  tx_state_t              state_reg, state_next;
  logic [8:0]             shift_reg, shift_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [INH_W-1:0]       inh_cnt_reg, inh_cnt_next;
  logic [WD_W-1:0]        wd_cnt_reg, wd_cnt_next;
  logic                   c_low, d_low, done_pulse, err_pulse, timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      inh_cnt_reg <= '0;
      wd_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      inh_cnt_reg <= inh_cnt_next;
      wd_cnt_reg  <= wd_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    inh_cnt_next = inh_cnt_reg;
    wd_cnt_next  = wd_cnt_reg;
    c_low        = 1'b0;
    d_low        = 1'b0;
    done_pulse   = 1'b0;
    err_pulse    = 1'b0;
    timeout      = (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES));

    unique case (state_reg)
      IDLE: begin
        if (wr_ps2) begin
          shift_next   = build_frame(din);
          inh_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = INHIBIT;
        end
      end
      INHIBIT: begin
        c_low = 1'b1;
        d_low = (inh_cnt_reg >= INH_W'(DATA_LOW_FROM));
        if (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 1)) begin
          wd_cnt_next = '0;
          state_next  = START;
        end else begin
          inh_cnt_next = inh_cnt_reg + 1'b1;
        end
      end
      START: begin
        d_low = 1'b1;
        if (fall) begin
          // Nine bit slots remain: d0..d7 and parity.
          bit_cnt_next = BIT_CNT_W'(9);
          state_next   = DATA;
        end
      end
      DATA: begin
        d_low = ~shift_reg[0];
        if (fall) begin
          if (bit_cnt_reg == BIT_CNT_W'(1)) begin
            state_next = STOP;
          end else begin
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg - 1'b1;
          end
        end
      end
      STOP: begin
        if (fall) begin
          if (!ps2d_sync) begin
            state_next = WAIT_IDLE;
          end else begin
            err_pulse  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (ps2c_filt && ps2d_sync) begin
          done_pulse = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Watchdog overrides whatever the bit logic decided this cycle.
    if (state_reg inside {START, DATA, STOP, WAIT_IDLE}) begin
      if (timeout) begin
        c_low      = 1'b0;
        d_low      = 1'b0;
        done_pulse = 1'b0;
        err_pulse  = 1'b1;
        state_next = IDLE;
      end else begin
        wd_cnt_next = wd_cnt_reg + 1'b1;
      end
    end
  end

  // Line drives decode straight from the state register, so an
  // asynchronous reset releases the bus without waiting for a clock.
  assign ps2c_drive_low = c_low;
  assign ps2d_drive_low = d_low;
  assign tx_busy        = (state_reg != IDLE);
  assign tx_done        = done_pulse;
  assign tx_err         = err_pulse;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 64;
  localparam int TO   = 2000;
  localparam int FL   = 8;
  localparam int HALF = 40;   // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_drive_low, ps2d_drive_low;
  logic       tx_busy, tx_done, tx_err;

  int checks = 0;
  int passed = 0;

  // Open-collector bus: either side may pull a line low.
  assign ps2c_in = dev_clk & ~ps2c_drive_low;
  assign ps2d_in = dev_data & ~ps2d_drive_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_ps2        (wr_ps2),
    .din           (din),
    .ps2c_in       (ps2c_in),
    .ps2d_in       (ps2d_in),
    .ps2c_drive_low(ps2c_drive_low),
    .ps2d_drive_low(ps2d_drive_low),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_err        (tx_err)
  );

  // Bus monitor: pulse counts and clock-inhibit measurements.
  int         done_total = 0, err_total = 0, both_total = 0, long_pulse = 0;
  int         c_run = 0, cd_run = 0, last_c_run = 0, last_cd_run = 0;
  logic       pulse_prev = 1'b0, pulse_busy = 1'b0, after_busy = 1'b1;
  logic [1:0] pulse_lines = 2'b11;

  always @(negedge clk) begin
    if (pulse_prev) after_busy = tx_busy;
    if (tx_done && tx_err) both_total++;
    if (tx_done) done_total++;
    if (tx_err) err_total++;
    if ((tx_done || tx_err) && pulse_prev) long_pulse++;
    if (tx_done || tx_err) begin
      pulse_busy  = tx_busy;
      pulse_lines = {ps2c_drive_low, ps2d_drive_low};
    end
    pulse_prev = tx_done | tx_err;
    if (ps2c_drive_low) begin
      c_run++;
      if (ps2d_drive_low) cd_run++;
    end else if (c_run != 0) begin
      last_c_run  = c_run;
      last_cd_run = cd_run;
      c_run       = 0;
      cd_run      = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: what a device sees on its rising edges -- start 0, data LSB
  // first, odd parity, stop 1.
  function automatic logic [10:0] expected_bits(input logic [7:0] b);
    logic [10:0] e;
    e[0] = 1'b0;
    for (int i = 0; i < 8; i++) e[i+1] = b[i];
    e[9]  = ($countones(b) % 2 == 0);
    e[10] = 1'b1;
    return e;
  endfunction

  // Device model: waits for request-to-send, clocks 10 bits, then clocks
  // f11 with data low (ACK) or high (NACK). Optional host write at a given
  // fall and reset after a given fall.
  task automatic device_frame(input bit ack, input bit glitch, input int wr_at,
                              input int reset_at, output logic [10:0] bits,
                              output bit seen);
    int t;
    bits = '0;
    seen = 1'b0;
    t = 0;
    while (!ps2c_drive_low && t < 4 * INH) begin @(negedge clk); t++; end
    t = 0;
    while (ps2c_drive_low && t < 4 * INH) begin @(negedge clk); t++; end
    if (ps2c_drive_low) return;
    seen = 1'b1;
    repeat (HALF) @(negedge clk);
    bits[0] = ps2d_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      bits[k] = ps2d_in;
      if (k == wr_at) begin
        din    = CMD_RESET;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end else begin
        @(negedge clk);
      end
      if (k == reset_at) begin
        reset = 1'b1;
        return;
      end
      if (glitch && k < 9) begin
        repeat (19) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 23) @(negedge clk);
      end else begin
        repeat (HALF - 1) @(negedge clk);
      end
    end
    if (ack) dev_data = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input bit ack, input bit glitch);
    logic [10:0] bits;
    bit          seen;
    int          d0, e0, t;
    @(negedge clk);
    #1;
    d0     = done_total;
    e0     = err_total;
    din    = b;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    check("busy_after_wr", 32'(tx_busy), 32'd1);
    device_frame(ack, glitch, 0, 0, bits, seen);
    t = 0;
    while (tx_busy && t < 400) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    #1;
    check("clk_released", 32'(seen), 32'd1);
    check("inhibit_len", 32'(last_c_run), 32'(INH));
    check("data_low_in_inhibit", 32'(last_cd_run), 32'(INH / 8));
    check("frame_bits", 32'(bits), 32'(expected_bits(b)));
    check("done_count", 32'(done_total - d0), 32'(ack));
    check("err_count", 32'(err_total - e0), 32'(!ack));
    check("busy_at_pulse", 32'(pulse_busy), 32'd1);
    check("lines_at_pulse", 32'(pulse_lines), 32'd0);
    check("busy_after_pulse", 32'(after_busy), 32'd0);
    check("idle_state", 32'({tx_busy, ps2c_drive_low, ps2d_drive_low}), 32'd0);
    $display("frame din=%02h ack=%0d glitch=%0d bits=%b done=%0d err=%0d",
             b, ack, glitch, bits, done_total - d0, err_total - e0);
  endtask

  initial begin
    logic [10:0] bits;
    logic [10:0] exp_ed;
    bit          seen;
    int          d0, e0, t, cnt;
    logic [7:0]  rb;
    bit          rack;

    reset    = 1'b1;
    wr_ps2   = 1'b0;
    din      = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done, tx_err}), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_outputs", 32'({ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done, tx_err}), 32'd0);
    $display("reset released, outputs idle");

    do_frame(CMD_SET_LEDS, 1'b1, 1'b0);
    do_frame(CMD_ENABLE, 1'b1, 1'b0);
    do_frame(8'h00, 1'b0, 1'b0);

    // Device never clocks: watchdog must end the transfer.
    @(negedge clk);
    #1;
    d0     = done_total;
    e0     = err_total;
    din    = 8'h55;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    t = 0;
    while (!ps2c_drive_low && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (ps2c_drive_low && t < 4 * INH) begin @(negedge clk); t++; end
    cnt = 0;
    while (ps2d_drive_low && cnt < TO + 100) begin cnt++; @(negedge clk); end
    check("timeout_hold", 32'(cnt), 32'(TO));
    check("timeout_pulse", 32'({tx_err, tx_done, ps2c_drive_low, ps2d_drive_low, tx_busy}), 32'b10001);
    @(negedge clk);
    check("timeout_busy_drop", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("timeout_err_count", 32'(err_total - e0), 32'd1);
    check("timeout_done_count", 32'(done_total - d0), 32'd0);
    $display("timeout din=55 hold=%0d err=%0d", cnt, err_total - e0);

    // Write during busy is ignored; reset mid-frame releases the bus.
    exp_ed = expected_bits(CMD_SET_LEDS);
    @(negedge clk);
    #1;
    d0     = done_total;
    e0     = err_total;
    din    = CMD_SET_LEDS;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    device_frame(1'b1, 1'b0, 4, 6, bits, seen);
    #1;
    check("reset_midframe_outputs", 32'({ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done, tx_err}), 32'd0);
    check("prefix_bits_before_reset", 32'(bits[6:0]), 32'(exp_ed[6:0]));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("no_queued_write", 32'(tx_busy), 32'd0);
    check("reset_no_pulses", 32'((done_total - d0) + (err_total - e0)), 32'd0);
    $display("reset midframe din=ED prefix=%b busy=%0d", bits[6:0], tx_busy);
    do_frame(CMD_ENABLE, 1'b1, 1'b0);

    // Clock glitches during DATA must not skip bits.
    do_frame(CMD_SET_LEDS, 1'b1, 1'b1);

    // Random bytes with random ACK/NACK.
    for (int i = 0; i < 3; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      do_frame(rb, rack, 1'b0);
    end

    repeat (2) @(negedge clk);
    #1;
    check("never_both_pulses", 32'(both_total), 32'd0);
    check("pulses_single_cycle", 32'(long_pulse), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
